// File: rtl/simple_processor_pkg.sv
// Shared types and constants for the simple processor and its memory-port arbiter.
package simple_processor_pkg;

    localparam int ADDR_WIDTH = 16;
    localparam int DATA_WIDTH = 16;

    localparam int ARB_MAX_DMEM_BURST = 4;
    localparam int ARB_ACK_TIMEOUT    = 256;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and shared-memory signals around the arbiter.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = simple_processor_pkg::ADDR_WIDTH,
    parameter int DATA_W = simple_processor_pkg::DATA_WIDTH
) ();

    logic              imem_req_i;
    logic [ADDR_W-1:0] imem_addr_i;
    logic [DATA_W-1:0] imem_rdata_o;
    logic              imem_ack_o;

    logic              dmem_req_i;
    logic              dmem_we_i;
    logic [ADDR_W-1:0] dmem_addr_i;
    logic [DATA_W-1:0] dmem_wdata_i;
    logic [DATA_W-1:0] dmem_rdata_o;
    logic              dmem_ack_o;

    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              mem_ack_i;

    logic              err_timeout_o;

    // Arbiter view.
    modport slave (
        input  imem_req_i, imem_addr_i,
        output imem_rdata_o, imem_ack_o,
        input  dmem_req_i, dmem_we_i, dmem_addr_i, dmem_wdata_i,
        output dmem_rdata_o, dmem_ack_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i, mem_ack_i,
        output err_timeout_o
    );

    // Core plus memory view.
    modport master (
        output imem_req_i, imem_addr_i,
        input  imem_rdata_o, imem_ack_o,
        output dmem_req_i, dmem_we_i, dmem_addr_i, dmem_wdata_i,
        input  dmem_rdata_o, dmem_ack_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i, mem_ack_i,
        input  err_timeout_o
    );

endinterface

// File: rtl/arb_watchdog.sv
// Timeout counter: counts enabled cycles since the last clear and flags
// the last allowed cycle so a bus master can force completion.
module arb_watchdog #(
    parameter int TIMEOUT = 256
) (
    input  logic clk_i,
    input  logic arst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_cnt <= '0;
        end else if (clear_i) begin
            r_cnt <= '0;
        end else if (enable_i && !expire_o) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign expire_o = (r_cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and data requesters: data
// wins, a burst limit prevents fetch starvation, a watchdog bounds each access.
module mem_port_arbiter
    import simple_processor_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = ADDR_WIDTH,
    parameter int MEM_DATA_WIDTH = DATA_WIDTH,
    parameter int MAX_DMEM_BURST = ARB_MAX_DMEM_BURST,
    parameter int ACK_TIMEOUT    = ARB_ACK_TIMEOUT
) (
    input  logic              clk_i,
    input  logic              arst_ni,
    mem_port_arbiter_if.slave bus
);

    localparam int BURST_W = $clog2(MAX_DMEM_BURST + 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_DMEM_BURST);

    arb_state_e                r_state, w_state_next;
    logic [BURST_W-1:0]        r_burst_cnt, w_burst_next;
    logic                      r_mem_req, w_mem_req_next;
    logic                      r_mem_we, w_mem_we_next;
    logic [MEM_ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_next;
    logic [MEM_DATA_WIDTH-1:0] r_mem_wdata, w_mem_wdata_next;
    logic                      r_err, w_err_next;

    logic                      w_busy, w_expire, w_done, w_forced;
    logic                      w_grant_d, w_grant_i;
    logic [MEM_DATA_WIDTH-1:0] w_rdata;

    assign w_busy    = (r_state != IDLE);
    assign w_done    = w_busy && (bus.mem_ack_i || w_expire);
    // A real ack in the expiry cycle wins over the forced completion.
    assign w_forced  = w_busy && w_expire && !bus.mem_ack_i;
    assign w_grant_d = bus.dmem_req_i && (!bus.imem_req_i || (r_burst_cnt < BURST_MAX));
    assign w_grant_i = !w_grant_d && bus.imem_req_i;
    assign w_rdata   = bus.mem_ack_i ? bus.mem_rdata_i : '0;

    arb_watchdog #(
        .TIMEOUT (ACK_TIMEOUT)
    ) u_watchdog (
        .clk_i    (clk_i),
        .arst_ni  (arst_ni),
        .clear_i  (!w_busy),
        .enable_i (w_busy && !bus.mem_ack_i),
        .expire_o (w_expire)
    );

    always_comb begin
        w_state_next     = r_state;
        w_burst_next     = r_burst_cnt;
        w_mem_req_next   = r_mem_req;
        w_mem_we_next    = r_mem_we;
        w_mem_addr_next  = r_mem_addr;
        w_mem_wdata_next = r_mem_wdata;
        w_err_next       = r_err;
        case (r_state)
            IDLE: begin
                if (w_grant_d) begin
                    w_state_next     = BUSY_D;
                    w_mem_req_next   = 1'b1;
                    w_mem_we_next    = bus.dmem_we_i;
                    w_mem_addr_next  = bus.dmem_addr_i;
                    w_mem_wdata_next = bus.dmem_wdata_i;
                    if (!bus.imem_req_i)
                        w_burst_next = '0;
                    else if (r_burst_cnt != BURST_MAX)
                        w_burst_next = r_burst_cnt + 1'b1;
                end else if (w_grant_i) begin
                    w_state_next     = BUSY_I;
                    w_mem_req_next   = 1'b1;
                    w_mem_we_next    = 1'b0;
                    w_mem_addr_next  = bus.imem_addr_i;
                    w_mem_wdata_next = '0;
                    w_burst_next     = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                if (w_done) begin
                    w_state_next   = IDLE;
                    w_mem_req_next = 1'b0;
                end
                if (w_forced)
                    w_err_next = 1'b1;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_state     <= IDLE;
            r_burst_cnt <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_burst_cnt <= w_burst_next;
            r_mem_req   <= w_mem_req_next;
            r_mem_we    <= w_mem_we_next;
            r_mem_addr  <= w_mem_addr_next;
            r_mem_wdata <= w_mem_wdata_next;
            r_err       <= w_err_next;
        end
    end

    assign bus.imem_ack_o    = w_done && (r_state == BUSY_I);
    assign bus.dmem_ack_o    = w_done && (r_state == BUSY_D);
    assign bus.imem_rdata_o  = bus.imem_ack_o ? w_rdata : '0;
    assign bus.dmem_rdata_o  = bus.dmem_ack_o ? w_rdata : '0;
    assign bus.mem_req_o     = r_mem_req;
    assign bus.mem_we_o      = r_mem_we;
    assign bus.mem_addr_o    = r_mem_addr;
    assign bus.mem_wdata_o   = r_mem_wdata;
    assign bus.err_timeout_o = r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed jobs feed two requester
// models and a memory responder; a monitor checks every grant and ack.
module tb_mem_port_arbiter;
    import simple_processor_pkg::*;

    typedef struct {
        bit          is_d;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } job_t;

    typedef struct {
        bit          is_d;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          lat;
        bit          err;
    } exp_t;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mem_port_arbiter #(
        .MEM_ADDR_WIDTH (16),
        .MEM_DATA_WIDTH (16),
        .MAX_DMEM_BURST (4),
        .ACK_TIMEOUT    (256)
    ) dut (
        .clk_i   (clk),
        .arst_ni (arst_n),
        .bus     (bus)
    );

    job_t iq[$];
    job_t dq[$];
    exp_t grant_q[$];
    exp_t ack_q[$];

    int tests = 0;
    int errors = 0;
    int cyc = 0;
    int mem_lat = 0;
    bit mem_dead = 1'b0;
    bit i_busy = 1'b0, d_busy = 1'b0, i_acked = 1'b0, d_acked = 1'b0;
    int t_grant = 0;
    bit prev_req = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic expect_txn(input bit is_d, input bit we, input logic [15:0] addr,
                              input logic [15:0] wdata, input logic [15:0] rdata,
                              input int lat, input bit err);
        exp_t e;
        e = '{is_d: is_d, we: we, addr: addr, wdata: wdata, rdata: rdata, lat: lat, err: err};
        grant_q.push_back(e);
        ack_q.push_back(e);
    endtask

    task automatic add_job(input bit is_d, input bit we, input logic [15:0] addr, input logic [15:0] wdata);
        job_t j;
        j = '{is_d: is_d, we: we, addr: addr, wdata: wdata};
        if (is_d) dq.push_back(j);
        else      iq.push_back(j);
    endtask

    task automatic txn(input bit is_d, input bit we, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic [15:0] rdata,
                       input int lat, input bit err);
        expect_txn(is_d, we, addr, is_d ? wdata : 16'h0000, rdata, lat, err);
        add_job(is_d, we, addr, wdata);
    endtask

    task automatic wait_drain(input int max_cycles);
        int n;
        n = 0;
        while ((ack_q.size() > 0 || iq.size() > 0 || dq.size() > 0 || i_busy || d_busy)
               && n < max_cycles) begin
            @(posedge clk);
            n++;
        end
        check("drain_in_time", n < max_cycles, 1);
        if (n >= max_cycles) begin
            ack_q.delete();
            grant_q.delete();
            iq.delete();
            dq.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    // Fetch requester.
    initial begin
        job_t j;
        bus.imem_req_i  = 1'b0;
        bus.imem_addr_i = '0;
        forever begin
            @(posedge clk);
            #1;
            if (i_busy && i_acked) begin
                i_busy = 1'b0;
                i_acked = 1'b0;
                bus.imem_req_i = 1'b0;
            end
            if (!i_busy && iq.size() > 0) begin
                j = iq.pop_front();
                bus.imem_addr_i = j.addr;
                bus.imem_req_i  = 1'b1;
                i_busy = 1'b1;
            end
        end
    end

    // Data requester.
    initial begin
        job_t j;
        bus.dmem_req_i   = 1'b0;
        bus.dmem_we_i    = 1'b0;
        bus.dmem_addr_i  = '0;
        bus.dmem_wdata_i = '0;
        forever begin
            @(posedge clk);
            #1;
            if (d_busy && d_acked) begin
                d_busy = 1'b0;
                d_acked = 1'b0;
                bus.dmem_req_i = 1'b0;
            end
            if (!d_busy && dq.size() > 0) begin
                j = dq.pop_front();
                bus.dmem_we_i    = j.we;
                bus.dmem_addr_i  = j.addr;
                bus.dmem_wdata_i = j.wdata;
                bus.dmem_req_i   = 1'b1;
                d_busy = 1'b1;
            end
        end
    end

    // Memory responder: acks mem_lat cycles after mem_req_o rises; data = addr ^ 5A5A.
    initial begin
        int wcnt;
        wcnt = 0;
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_rdata_i = bus.mem_req_o ? (bus.mem_addr_o ^ 16'h5A5A) : 16'h0000;
            if (!bus.mem_req_o || bus.mem_ack_i) begin
                bus.mem_ack_i = 1'b0;
                wcnt = 0;
            end else if (!mem_dead && wcnt == mem_lat) begin
                bus.mem_ack_i = 1'b1;
            end else begin
                wcnt++;
            end
        end
    end

    // Monitor: checks each new memory request and each requester ack.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!arst_n) begin
                prev_req = 1'b0;
            end else begin
                if (bus.mem_req_o && !prev_req) begin
                    check("grant_expected", grant_q.size() > 0, 1);
                    if (grant_q.size() > 0) begin
                        e = grant_q.pop_front();
                        check("grant_we", bus.mem_we_o, e.we);
                        check("grant_addr", bus.mem_addr_o, e.addr);
                        check("grant_wdata", bus.mem_wdata_o, e.wdata);
                    end
                    t_grant = cyc;
                end
                prev_req = bus.mem_req_o;
                if (bus.imem_ack_o || bus.dmem_ack_o) begin
                    check("ack_exclusive", bus.imem_ack_o && bus.dmem_ack_o, 0);
                    if (bus.imem_ack_o) i_acked = 1'b1;
                    if (bus.dmem_ack_o) d_acked = 1'b1;
                    check("ack_expected", ack_q.size() > 0, 1);
                    if (ack_q.size() > 0) begin
                        e = ack_q.pop_front();
                        check("ack_port", bus.dmem_ack_o, e.is_d);
                        check("ack_rdata", e.is_d ? bus.dmem_rdata_o : bus.imem_rdata_o, e.rdata);
                        check("ack_latency", cyc - t_grant, e.lat);
                        check("ack_err", bus.err_timeout_o, e.err);
                        $display("[TB] ack %s addr=%04h rdata=%04h lat=%0d err=%0b",
                                 e.is_d ? "D" : "I", e.addr,
                                 e.is_d ? bus.dmem_rdata_o : bus.imem_rdata_o,
                                 cyc - t_grant, bus.err_timeout_o);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish (cycle %0d)", cyc);
        $fatal(1, "global timeout");
    end

    initial begin
        logic [15:0] st_addr  [10];
        logic [15:0] st_rdata [10];
        bit          st_d     [10];
        int          n;

        st_addr  = '{16'h0100, 16'h0101, 16'h0102, 16'h0103, 16'h0200,
                     16'h0104, 16'h0105, 16'h0106, 16'h0107, 16'h0201};
        st_rdata = '{16'h5B5A, 16'h5B5B, 16'h5B58, 16'h5B59, 16'h585A,
                     16'h5B5E, 16'h5B5F, 16'h5B5C, 16'h5B5D, 16'h585B};
        st_d     = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

        // Reset values.
        arst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_req",    bus.mem_req_o, 0);
        check("rst_mem_we",     bus.mem_we_o, 0);
        check("rst_mem_addr",   bus.mem_addr_o, 0);
        check("rst_mem_wdata",  bus.mem_wdata_o, 0);
        check("rst_imem_ack",   bus.imem_ack_o, 0);
        check("rst_dmem_ack",   bus.dmem_ack_o, 0);
        check("rst_imem_rdata", bus.imem_rdata_o, 0);
        check("rst_dmem_rdata", bus.dmem_rdata_o, 0);
        check("rst_err",        bus.err_timeout_o, 0);
        arst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Single fetch, memory latency 3.
        mem_lat = 3;
        txn(0, 0, 16'h0010, 16'h0000, 16'h5A4A, 3, 0);
        wait_drain(50);

        // Simultaneous requests: data write first, then fetch.
        mem_lat = 2;
        txn(1, 1, 16'h0040, 16'hBEEF, 16'h5A1A, 2, 0);
        txn(0, 0, 16'h0050, 16'h0000, 16'h5A0A, 2, 0);
        wait_drain(50);

        // Starvation guard: D,D,D,D,I,D,D,D,D,I.
        mem_lat = 1;
        for (int k = 0; k < 10; k++) begin
            expect_txn(st_d[k], 0, st_addr[k], 16'h0000, st_rdata[k], 1, 0);
            add_job(st_d[k], 0, st_addr[k], 16'h0000);
        end
        wait_drain(200);

        // Ack coinciding with watchdog expiry is a normal completion.
        mem_lat = 255;
        txn(1, 0, 16'h0060, 16'h0000, 16'h5A3A, 255, 0);
        wait_drain(400);
        check("err_after_coincide", bus.err_timeout_o, 0);

        // Reset during a fetch; the held request is re-granted afterwards.
        mem_lat = 20;
        grant_q.push_back('{is_d: 0, we: 0, addr: 16'h0030, wdata: 16'h0000,
                            rdata: 16'h5A6A, lat: 3, err: 0});
        txn(0, 0, 16'h0030, 16'h0000, 16'h5A6A, 3, 0);
        n = 0;
        while (!bus.mem_req_o && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reset_test_granted", bus.mem_req_o, 1);
        repeat (2) @(posedge clk);
        #3;
        arst_n = 1'b0;
        mem_lat = 3;
        #1;
        check("reset_mem_req_async", bus.mem_req_o, 0);
        check("reset_no_imem_ack",   bus.imem_ack_o, 0);
        @(posedge clk);
        #2;
        arst_n = 1'b1;
        wait_drain(60);

        // Dead memory: forced completion with zero data, sticky error.
        mem_dead = 1'b1;
        txn(1, 0, 16'h0080, 16'h0000, 16'h0000, 255, 0);
        wait_drain(400);
        mem_dead = 1'b0;
        check("err_set_after_timeout", bus.err_timeout_o, 1);
        mem_lat = 1;
        txn(0, 0, 16'h0090, 16'h0000, 16'h5ACA, 1, 1);
        wait_drain(50);
        check("err_still_set", bus.err_timeout_o, 1);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-ported memory between the instruction-fetch requester (imem_*) and the data requester (dmem_*) of the simple processor. It sits between the processor core and the unified memory, arbitrates per transaction, and routes the completion acknowledge and read data back to the winning requester. Data accesses normally win over fetches; a starvation guard guarantees forward progress for fetches. An acknowledge watchdog keeps the core from hanging on a dead memory.

Parameters:
MEM_ADDR_WIDTH, simple_processor_pkg::ADDR_WIDTH, width of all address buses
MEM_DATA_WIDTH, simple_processor_pkg::DATA_WIDTH, width of all data buses
MAX_DMEM_BURST, 4, maximum consecutive dmem grants while an imem request waits (>=1)
ACK_TIMEOUT, 256, cycles in BUSY without mem_ack_i before a forced completion (>=2)

Ports:
clk_i  in  1  global synchronous clock
arst_ni  in  1  asynchronous active-low reset
imem_req_i  in  1  fetch request pending
imem_addr_i  in  MEM_ADDR_WIDTH  fetch address
imem_rdata_o  out  MEM_DATA_WIDTH  fetch read data, valid with imem_ack_o
imem_ack_o  out  1  fetch complete, 1-cycle pulse
dmem_req_i  in  1  data request pending
dmem_we_i  in  1  1 = write
dmem_addr_i  in  MEM_ADDR_WIDTH  data address
dmem_wdata_i  in  MEM_DATA_WIDTH  write data
dmem_rdata_o  out  MEM_DATA_WIDTH  data read data, valid with dmem_ack_o
dmem_ack_o  out  1  data request complete, 1-cycle pulse
mem_req_o  out  1  request to shared memory
mem_we_o  out  1  write enable to shared memory
mem_addr_o  out  MEM_ADDR_WIDTH  shared memory address
mem_wdata_o  out  MEM_DATA_WIDTH  shared memory write data
mem_rdata_i  in  MEM_DATA_WIDTH  shared memory read data
mem_ack_i  in  1  shared memory transaction complete
err_timeout_o  out  1  sticky: at least one watchdog expiry since reset

Behaviour:
- Clock clk_i; reset arst_ni is asynchronous and active-low.
- Reset values: state IDLE; mem_req_o, mem_we_o, imem_ack_o, dmem_ack_o and err_timeout_o are 0; mem_addr_o, mem_wdata_o, imem_rdata_o and dmem_rdata_o are '0; burst and timeout counters are 0.
- Requester protocol: req, addr, we and wdata are held stable from assertion until the matching ack cycle. The requester may drop req or keep it asserted for a new transaction in the cycle after ack.
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE, grant rule:
  - dmem_req_i=1 and (imem_req_i=0 or burst_cnt<MAX_DMEM_BURST): go to BUSY_D; burst_cnt increments if imem_req_i=1, else clears.
  - Otherwise, if imem_req_i=1: go to BUSY_I; burst_cnt clears.
  - On the grant, mem_* outputs are registered from the winner. For a fetch, we=0 and wdata='0.
  - mem_req_o=1 from the cycle after the grant decision.
- BUSY_x:
  - mem_* outputs are held stable.
  - On mem_ack_i=1: go to IDLE, mem_req_o=0 next cycle. The owner's ack_o is asserted combinationally in the same cycle, and its rdata_o = mem_rdata_i. The non-owner's ack stays 0.
- Minimum turnaround: one IDLE cycle between transactions. Back-to-back throughput is therefore one transaction per (memory latency + 2) cycles.
- mem_ack_i in IDLE is ignored.
- If the owner drops req before ack (protocol violation), the transaction still completes and the ack is still pulsed to the owner.
- Watchdog:
  - Counter clears on entry to BUSY_x and increments each BUSY cycle without ack.
  - At ACK_TIMEOUT-1 it forces completion: owner ack_o pulses with rdata_o='0, err_timeout_o sets (sticky until reset), state goes to IDLE.
  - A mem_ack_i arriving in the same cycle takes precedence: normal completion, no error.
- Reset mid-transaction aborts everything immediately: outputs return to reset values and no ack is issued. Requesters still holding req are re-arbitrated after reset release.
- Width rules: burst counter is $clog2(MAX_DMEM_BURST+1) bits and saturates. Timeout counter is $clog2(ACK_TIMEOUT) bits.

Decomposition:
- simple_processor_pkg gains arb_state_e (IDLE, BUSY_I, BUSY_D), plus the constants ARB_MAX_DMEM_BURST=4 and ARB_ACK_TIMEOUT=256 used as parameter defaults.
- One sub-module is natural: arb_watchdog (clear, enable, expire_o), a parameterised timeout counter that is reusable for other bus masters.

Test Plan:
- Single fetch: imem_req_i=1, addr=0x0010; memory acks 3 cycles after mem_req_o -> mem_addr_o=0x0010, mem_we_o=0; imem_ack_o pulses once with imem_rdata_o=mem_rdata_i; dmem_ack_o stays 0.
- Simultaneous requests: both req at cycle 0, dmem write addr=0x0040, wdata=0xBEEF -> dmem served first (mem_we_o=1), then imem. Grant order D, I.
- Starvation guard: dmem_req_i and imem_req_i held high continuously, MAX_DMEM_BURST=4 -> grant sequence D,D,D,D,I,D,D,D,D,I.
- Watchdog: dmem read, mem_ack_i never asserted, ACK_TIMEOUT=256 -> dmem_ack_o pulses 255 cycles after BUSY entry with rdata='0; err_timeout_o=1 and stays 1. The next request completes normally.
- Ack on the last watchdog cycle: mem_ack_i coincides with expiry -> normal ack with real rdata; err_timeout_o stays 0.
- Reset in BUSY_I: arst_ni pulsed low mid-fetch -> mem_req_o=0 asynchronously and no imem_ack_o. After release, the held imem request is regranted and completes.
